// File: rtl/uart_tx_sched.sv
// uart_tx_sched: programs a UART over APB, then round-robins requester bytes into its TX data register.
// Latency: best case 5 cycles accept-to-accept (ARB 1, FSTAT poll 2, TX write 2) with pready held high.
// Backpressure: FSTAT is re-polled until TX-full clears; requesters wait in ARB and a packet keeps the lock until its last byte.
module uart_tx_sched #(
  parameter int          N_REQ      = 4,
  parameter logic [15:0] ADDR_CSR   = 16'h0000,
  parameter logic [15:0] ADDR_DIV   = 16'h0004,
  parameter logic [15:0] ADDR_FSTAT = 16'h0008,
  parameter logic [15:0] ADDR_TX    = 16'h000c,
  parameter logic [31:0] CSR_INIT   = 32'h0000_0001,
  parameter logic [31:0] DIV_INIT   = 32'h0000_0270,
  parameter int          TXFULL_BIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [15:0]        apbm_paddr,
  output logic [31:0]        apbm_pwdata,
  input  logic [31:0]        apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr,
  output logic               cfg_done,
  output logic               busy,
  output logic               err
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {CFG_DIV, CFG_CSR, ARB, POLL, WRITE} state_t;

  state_t        state_q, state_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [15:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          cfg_done_q, cfg_done_d, err_q, err_d;
  logic [IW-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [7:0]    hold_dat_q, hold_dat_d;
  logic          hold_last_q, hold_last_d;

  logic          gnt_vld, gnt_last;
  logic [IW-1:0] gnt_idx, cand;
  logic [7:0]    gnt_dat;
  logic          xfer_done;
  logic          start_vld, start_write;
  logic [15:0]   start_addr;
  logic [31:0]   start_data;

  // Only the TX-full flag of FSTAT is meaningful; the remaining read bits are ignored.
  logic unused_prdata;
  assign unused_prdata = ^apbm_prdata;

  assign xfer_done = psel_q & penable_q & apbm_pready;

  // Grant selection: a locked requester is the only candidate, otherwise rotate from the last grant.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    gnt_dat  = '0;
    gnt_last = 1'b0;
    req_ready = '0;
    if (state_q == ARB) begin
      if (lock_q) begin
        gnt_vld = req_valid[lock_idx_q];
        gnt_idx = lock_idx_q;
      end else begin
        for (int i = 1; i <= N_REQ; i++) begin
          cand = IW'((int'(ptr_q) + i) % N_REQ);
          if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        gnt_dat  = req_data[8*i +: 8];
        gnt_last = req_last[i];
      end
      req_ready[i] = gnt_vld && (gnt_idx == IW'(i));
    end
  end

  // Sequencer: init writes, grant/poll/write loop, and APB SETUP/ACCESS phasing.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    cfg_done_d  = cfg_done_q;
    err_d       = err_q | (xfer_done & apbm_pslverr);
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    hold_dat_d  = hold_dat_q;
    hold_last_d = hold_last_q;
    start_vld   = 1'b0;
    start_write = 1'b0;
    start_addr  = paddr_q;
    start_data  = '0;
    case (state_q)
      CFG_DIV: begin
        if (!psel_q) begin
          start_vld   = 1'b1;
          start_write = 1'b1;
          start_addr  = ADDR_DIV;
          start_data  = DIV_INIT;
        end else if (xfer_done) begin
          state_d     = CFG_CSR;
          start_vld   = 1'b1;
          start_write = 1'b1;
          start_addr  = ADDR_CSR;
          start_data  = CSR_INIT;
        end
      end
      CFG_CSR: begin
        if (xfer_done) begin
          state_d    = ARB;
          cfg_done_d = 1'b1;
        end
      end
      ARB: begin
        if (gnt_vld) begin
          hold_dat_d  = gnt_dat;
          hold_last_d = gnt_last;
          ptr_d       = gnt_idx;
          state_d     = POLL;
          start_vld   = 1'b1;
          start_addr  = ADDR_FSTAT;
        end
      end
      POLL: begin
        if (xfer_done) begin
          start_vld = 1'b1;
          if (apbm_prdata[TXFULL_BIT]) begin
            start_addr = ADDR_FSTAT;
          end else begin
            state_d     = WRITE;
            start_write = 1'b1;
            start_addr  = ADDR_TX;
            start_data  = {24'h0, hold_dat_q};
          end
        end
      end
      WRITE: begin
        if (xfer_done) begin
          state_d    = ARB;
          lock_d     = ~hold_last_q;
          lock_idx_d = ptr_q;
        end
      end
      default: state_d = CFG_DIV;
    endcase
    // A new transfer always opens with SETUP, even straight after a completion.
    if (start_vld) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = start_write;
      paddr_d   = start_addr;
      pwdata_d  = start_data;
    end else if (psel_q && !penable_q) begin
      penable_d = 1'b1;
    end else if (xfer_done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CFG_DIV;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= IW'(N_REQ - 1);
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      hold_dat_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cfg_done_q  <= cfg_done_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      hold_dat_q  <= hold_dat_d;
      hold_last_q <= hold_last_d;
    end
  end

  assign apbm_psel    = psel_q;
  assign apbm_penable = penable_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwdata  = pwdata_q;
  assign cfg_done     = cfg_done_q;
  assign err          = err_q;
  assign busy         = !((state_q == ARB) && !gnt_vld);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed phases plus random rounds against a packet-level round-robin model.
// Latency: checks init timing, 5-cycle grant spacing and FSTAT/TX write sequencing.
// Backpressure: APB slave inserts wait states and TX-full responses; requester valid can gap mid-packet.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           psel, penable, pwrite, pready, pslverr;
  logic [15:0]    paddr;
  logic [31:0]    pwdata, prdata;
  logic           cfg_done, busy, err;

  uart_tx_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .apbm_psel(psel), .apbm_penable(penable), .apbm_pwrite(pwrite), .apbm_paddr(paddr),
    .apbm_pwdata(pwdata), .apbm_prdata(prdata), .apbm_pready(pready), .apbm_pslverr(pslverr),
    .cfg_done(cfg_done), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [8:0]  rq [N][$];   // bytes still to be offered by each requester: {last, data}
  logic [8:0]  mq [N][$];   // same streams, consumed by the reference model
  int          exp_gnt[$];
  logic [7:0]  exp_tx[$];
  int          mptr;
  int          pop_pend;
  logic [N-1:0] gap;

  int          wait_max, wait_left, full_pct, full_left;
  logic        stall, err_on_tx;
  logic [15:0] c_addr;
  logic        c_wr;
  logic [31:0] c_data;
  logic        prev_psel, prev_rdy;
  int          n_grant = 0, n_fstat = 0, n_tx = 0, n_full = 0;
  logic [15:0] log_addr[$];
  logic [31:0] log_data[$];
  int          gnt_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !gap[i]) begin
        e = rq[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  // APB slave, handshake observer and scoreboard; runs mid-cycle.
  task automatic monitor();
    int   gi;
    logic full;
    if (rst) begin
      pready = 1'b0; pslverr = 1'b0; prev_psel = 1'b0; prev_rdy = 1'b0;
      return;
    end
    if (req_ready != '0) begin
      gi = 0;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) gi = i;
      chk("rdy_onehot", 32'($onehot(req_ready)), 1);
      chk("rdy_single_cycle", prev_rdy, 0);
      chk("rdy_needs_valid", req_valid[gi], 1);
      chk("grant_expected", exp_gnt.size() > 0, 1);
      if (exp_gnt.size() > 0) chk("grant_order", gi, exp_gnt.pop_front());
      pop_pend = gi;
      n_grant++;
      gnt_cyc.push_back(cyc);
    end
    prev_rdy = |req_ready;
    if (psel) chk("busy_in_xfer", busy, 1);
    pslverr = 1'b0;
    prdata = $urandom;
    if (psel && !penable) begin
      c_addr = paddr; c_wr = pwrite; c_data = pwdata;
      wait_left = int'($urandom_range(wait_max));
      pready = 1'($urandom);
    end else if (psel && penable) begin
      chk("setup_before_access", prev_psel, 1);
      chk("paddr_stable", paddr, c_addr);
      chk("pwrite_stable", pwrite, c_wr);
      chk("pwdata_stable", pwdata, c_data);
      if (stall || wait_left > 0) begin
        pready = 1'b0;
        if (!stall) wait_left--;
      end else begin
        pready = 1'b1;
        log_addr.push_back(paddr);
        log_data.push_back(pwdata);
        if (!pwrite && paddr == 16'h0008) begin
          full = (full_left > 0) || ($urandom_range(99) < full_pct);
          if (full_left > 0) full_left--;
          prdata[8] = full;
          n_fstat++;
          if (full) n_full++;
        end
        if (pwrite && paddr == 16'h000c) begin
          n_tx++;
          chk("tx_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) chk("tx_data", pwdata, {24'h0, exp_tx.pop_front()});
          if (err_on_tx) begin pslverr = 1'b1; err_on_tx = 1'b0; end
        end
      end
    end else begin
      pready = 1'($urandom);
    end
    prev_psel = psel;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (pop_pend >= 0) begin
      if (rq[pop_pend].size() > 0) void'(rq[pop_pend].pop_front());
      pop_pend = -1;
    end
    drive_reqs();
    @(negedge clk);
    monitor();
  endtask

  task automatic add_byte(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
    mq[i].push_back({last, d});
  endtask

  task automatic add_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
  endtask

  // Packet-level round robin: next non-empty requester after the last one served sends its whole packet.
  task automatic run_model();
    logic [8:0] e;
    int         i;
    bit         found;
    do begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        i = (mptr + k) % N;
        if (!found && mq[i].size() > 0) begin
          found = 1;
          mptr = i;
          do begin
            e = mq[i].pop_front();
            exp_gnt.push_back(i);
            exp_tx.push_back(e[7:0]);
          end while (!e[8] && mq[i].size() > 0);
        end
      end
    end while (found);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int   t = 0;
    logic ok;
    do begin
      tick();
      t++;
      ok = (exp_tx.size() == 0) && (exp_gnt.size() == 0) && !busy && !psel;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) ok = 1'b0;
    end while (!ok && t < max);
    chk(tag, ok, 1);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin rq[i].delete(); mq[i].delete(); end
    exp_gnt.delete(); exp_tx.delete(); log_addr.delete(); log_data.delete();
    gap = '0; stall = 1'b0; err_on_tx = 1'b0; full_left = 0; full_pct = 0; wait_max = 0;
    mptr = N - 1; pop_pend = -1;
    tick();
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_cfg_done"}, cfg_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // Called right after rst is released, with pready answering immediately.
  task automatic init_check();
    log_addr.delete(); log_data.delete();
    tick();
    chk("init_div_phase", {psel, penable}, 2'b10);
    chk("init_div_addr", paddr, 16'h0004);
    chk("init_div_wr", pwrite, 1);
    chk("init_div_data", pwdata, 32'h270);
    tick();
    chk("init_div_access", {psel, penable}, 2'b11);
    tick();
    chk("init_csr_phase", {psel, penable}, 2'b10);
    chk("init_csr_addr", paddr, 16'h0000);
    chk("init_csr_data", pwdata, 32'h1);
    tick();
    chk("cfg_done_cycle4", cfg_done, 0);
    tick();
    chk("cfg_done_cycle5", cfg_done, 1);
    chk("idle_psel", psel, 0);
    chk("idle_busy", busy, 0);
    repeat (10) tick();
    chk("no_apb_when_idle", log_addr.size(), 2);
  endtask

  task automatic random_round();
    int nf0, nr0, nt0;
    bit any = 0;
    wait_max = int'($urandom_range(2));
    full_pct = int'($urandom_range(40));
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(2, 1)) add_pkt(i, int'($urandom_range(3, 1)));
        any = 1;
      end
    end
    if (!any) add_pkt(int'($urandom_range(N - 1)), 2);
    nf0 = n_full; nr0 = n_fstat; nt0 = n_tx;
    run_model();
    wait_idle("rand_idle", 3000);
    chk("rand_poll_count", n_fstat - nr0, (n_tx - nt0) + (n_full - nf0));
  endtask

  initial begin
    int   g0, f0, t0, t;
    logic seen;
    rst = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    gap = '0; pop_pend = -1; prev_psel = 1'b0; prev_rdy = 1'b0; wait_left = 0;
    drive_reqs();

    apply_reset("por");
    rst = 1'b0;
    init_check();

    // Single byte from requester 0.
    g0 = n_grant; f0 = n_fstat; t0 = n_tx;
    add_byte(0, 8'h55, 1'b1);
    run_model();
    wait_idle("single_idle", 100);
    chk("single_grants", n_grant - g0, 1);
    chk("single_polls", n_fstat - f0, 1);
    chk("single_writes", n_tx - t0, 1);
    chk("single_tx_addr", log_addr[log_addr.size() - 1], 16'h000c);
    chk("single_tx_data", log_data[log_data.size() - 1], 32'h55);

    // TX-full three times before space appears.
    g0 = n_grant; f0 = n_fstat; t0 = n_tx;
    full_left = 3;
    add_byte(3, 8'($urandom), 1'b1);
    run_model();
    wait_idle("bp_idle", 200);
    chk("bp_polls", n_fstat - f0, 4);
    chk("bp_writes", n_tx - t0, 1);
    chk("bp_grants", n_grant - g0, 1);

    // All four requesters valid: order 0,1,2,3,0 at 5-cycle spacing.
    gnt_cyc.delete();
    add_byte(0, 8'($urandom), 1'b1);
    add_byte(0, 8'($urandom), 1'b1);
    for (int i = 1; i < N; i++) add_byte(i, 8'($urandom), 1'b1);
    run_model();
    wait_idle("rr_idle", 300);
    chk("rr_grants", gnt_cyc.size(), 5);
    for (int k = 0; k + 1 < gnt_cyc.size(); k++) chk("rr_spacing", gnt_cyc[k+1] - gnt_cyc[k], 5);

    // Packet lock with a valid gap in the middle of requester 1's packet.
    g0 = n_grant;
    add_pkt(1, 3);
    add_byte(0, 8'($urandom), 1'b1);
    add_byte(2, 8'($urandom), 1'b1);
    run_model();
    t = 0;
    while (n_grant == g0 && t < 50) begin tick(); t++; end
    chk("lock_first_grant", n_grant - g0, 1);
    gap[1] = 1'b1;
    g0 = n_grant;
    repeat (20) tick();
    chk("lock_gap_no_grant", n_grant, g0);
    chk("lock_gap_idle", busy, 0);
    gap[1] = 1'b0;
    wait_idle("lock_idle", 300);

    repeat (3) random_round();

    // Slave error on a TX write is sticky.
    chk("err_clear_before", err, 0);
    err_on_tx = 1'b1;
    add_byte(int'($urandom_range(N - 1)), 8'($urandom), 1'b1);
    run_model();
    wait_idle("err_idle", 200);
    chk("err_set", err, 1);
    repeat (2) random_round();
    chk("err_sticky", err, 1);

    // Reset while a FSTAT read is stuck in ACCESS.
    stall = 1'b1;
    add_byte(2, 8'($urandom), 1'b1);
    run_model();
    seen = 1'b0;
    t = 0;
    while (!seen && t < 50) begin
      tick();
      t++;
      seen = psel && penable && (paddr == 16'h0008);
    end
    chk("poll_access_reached", seen, 1);
    apply_reset("midreset");
    rst = 1'b0;
    init_check();
    random_round();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
